// File: rtl/qrd_pkg.sv
// Shared defaults for the output deskew block: lane count, lane word width,
// FIFO depth and the lane word type.
package qrd_pkg;

    localparam int DEF_LANES       = 4;
    localparam int DEF_DATA_LENGTH = 8;
    localparam int DEF_FIFO_DEPTH  = 4;

    typedef logic [DEF_DATA_LENGTH-1:0] lane_word_t;

endpackage : qrd_pkg

// File: rtl/lane_delay.sv
// Fixed-length shift register delaying one lane word by DEPTH cycles.
// With DEPTH=0 the lane passes straight through.
module lane_delay
    import qrd_pkg::*;
#(
    parameter int DEPTH       = 0,
    parameter int DATA_LENGTH = DEF_DATA_LENGTH
)(
    input  logic                   clk,
    input  logic [DATA_LENGTH-1:0] din,
    output logic [DATA_LENGTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_clk_s;
            assign unused_clk_s = clk;
            assign dout         = din;
        end else begin : g_shift
            logic [DATA_LENGTH-1:0] stage_r [DEPTH];

            // Data-only shift chain; stale words are harmless once the valid pipe is cleared.
            always_ff @(posedge clk) begin
                stage_r[0] <= din;
                for (int j = 1; j < DEPTH; j++) begin
                    stage_r[j] <= stage_r[j-1];
                end
            end

            assign dout = stage_r[DEPTH-1];
        end
    endgenerate

endmodule : lane_delay

// File: rtl/output_deskew.sv
// Re-aligns LANES staggered lanes into whole vectors and queues them in a
// small FIFO. Optional pop counter enabled by OUTPUT_DESKEW_CNT_EN.
module output_deskew
    import qrd_pkg::*;
#(
    parameter int LANES       = DEF_LANES,
    parameter int DATA_LENGTH = DEF_DATA_LENGTH,
    parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
)(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    input  logic [LANES*DATA_LENGTH-1:0] din,
    input  logic                         out_ready,
    output logic                         out_valid,
    output logic [LANES*DATA_LENGTH-1:0] dout,
    output logic                         overflow
`ifdef OUTPUT_DESKEW_CNT_EN
    ,
    output logic [15:0]                  vec_count
`endif
);

    localparam int W  = LANES * DATA_LENGTH;
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [W-1:0]      aligned_s;
    logic [LANES-2:0]  vld_r;
    logic [W-1:0]      mem_r [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [AW:0]       cnt_r;
    logic              out_valid_r;
    logic [W-1:0]      dout_r;
    logic              overflow_r;

    logic              wr_s;
    logic              pop_s;
    logic              full_s;
    logic              wr_en_s;
    logic              drop_s;
    logic [AW:0]       cnt_nxt_s;
    logic [AW-1:0]     rd_nxt_s;
    logic [W-1:0]      head_nxt_s;

    // Lane i arrives i cycles late, so it waits LANES-1-i stages to line up with the last lane.
    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            lane_delay #(
                .DEPTH       (LANES - 1 - i),
                .DATA_LENGTH (DATA_LENGTH)
            ) u_lane_delay (
                .clk  (clk),
                .din  (din[i*DATA_LENGTH +: DATA_LENGTH]),
                .dout (aligned_s[i*DATA_LENGTH +: DATA_LENGTH])
            );
        end
    endgenerate

    // Valid pipeline tracking each vector until its last lane has arrived.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_r <= '0;
        end else begin
            vld_r[0] <= in_valid;
            for (int j = 1; j < LANES - 1; j++) begin
                vld_r[j] <= vld_r[j-1];
            end
        end
    end

    assign wr_s    = vld_r[LANES-2];
    assign pop_s   = out_valid_r && out_ready;
    assign full_s  = (cnt_r == (AW+1)'(FIFO_DEPTH));
    assign wr_en_s = wr_s && (!full_s || pop_s);
    assign drop_s  = wr_s && full_s && !pop_s;

    // Next occupancy and next head word, so out_valid and dout can be registered.
    always_comb begin
        cnt_nxt_s  = cnt_r;
        rd_nxt_s   = rd_ptr_r;
        head_nxt_s = '0;
        if (wr_en_s && !pop_s) begin
            cnt_nxt_s = cnt_r + (AW+1)'(1);
        end else if (!wr_en_s && pop_s) begin
            cnt_nxt_s = cnt_r - (AW+1)'(1);
        end else begin
            cnt_nxt_s = cnt_r;
        end
        if (pop_s) begin
            rd_nxt_s = rd_ptr_r + AW'(1);
        end else begin
            rd_nxt_s = rd_ptr_r;
        end
        // The head slot is only written this edge when the FIFO is empty or drains to one entry.
        if (cnt_nxt_s == '0) begin
            head_nxt_s = '0;
        end else if (wr_en_s && (wr_ptr_r == rd_nxt_s)) begin
            head_nxt_s = aligned_s;
        end else begin
            head_nxt_s = mem_r[rd_nxt_s];
        end
    end

    // FIFO storage, written without reset; pointers and occupancy guard its contents.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= aligned_s;
        end
    end

    // FIFO control state and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            cnt_r       <= '0;
            out_valid_r <= 1'b0;
            dout_r      <= '0;
            overflow_r  <= 1'b0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            rd_ptr_r    <= rd_nxt_s;
            cnt_r       <= cnt_nxt_s;
            out_valid_r <= (cnt_nxt_s != '0);
            dout_r      <= head_nxt_s;
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    assign out_valid = out_valid_r;
    assign dout      = dout_r;
    assign overflow  = overflow_r;

`ifdef OUTPUT_DESKEW_CNT_EN
    logic [15:0] vec_count_r;

    // Saturating count of vectors handed to the consumer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vec_count_r <= 16'h0000;
        end else if (pop_s && (vec_count_r != 16'hFFFF)) begin
            vec_count_r <= vec_count_r + 16'h0001;
        end
    end

    assign vec_count = vec_count_r;
`endif

endmodule : output_deskew

// File: doc/output_deskew.md
OUTPUT_DESKEW -- requirements
Module: output_deskew

Interface
REQ-001 Parameter LANES, default 4: number of skewed data lanes (>=2).
REQ-002 Parameter DATA_LENGTH, default 8: bits per lane word.
REQ-003 Parameter FIFO_DEPTH, default 4: aligned-vector FIFO entries (power of two, >=2).
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset; synchronous, active-low.
REQ-006 in_valid  input  1  high in the cycle lane 0 carries word k of a new vector.
REQ-007 din  input  LANES*DATA_LENGTH  skewed lanes; lane i occupies bits [i*DATA_LENGTH +: DATA_LENGTH].
REQ-008 out_ready  input  1  consumer accepts the FIFO head when high with out_valid.
REQ-009 out_valid  output  1  FIFO non-empty.
REQ-010 dout  output  LANES*DATA_LENGTH  aligned vector at FIFO head, same lane packing as din.
REQ-011 overflow  output  1  sticky: an aligned vector was dropped.

Function
REQ-012 Skew contract: lane i of the vector tagged by in_valid in cycle n SHALL be sampled in cycle n+i; no input stall exists.
REQ-013 Lane i SHALL be delayed by LANES-1-i register stages; lane LANES-1 has zero stages.
REQ-014 in_valid SHALL be delayed LANES-1 stages in a valid pipeline; its output is the FIFO write strobe.
REQ-015 Write occurs on the edge ending cycle n+LANES-1; with empty FIFO, out_valid=1 and dout=vector in cycle n+LANES.
REQ-016 Back-to-back in_valid (every cycle) SHALL yield one aligned vector per cycle with no loss while FIFO has room.
REQ-017 Read: out_valid && out_ready pops the head on the clock edge; out_ready with empty FIFO has no effect.
REQ-018 dout SHALL hold stable while out_valid=1 and out_ready=0.
REQ-019 Write when full with simultaneous pop: both occur, occupancy unchanged, no overflow.
REQ-020 Write when full without pop: vector dropped, FIFO unchanged, overflow set and held until reset.
REQ-021 Write into empty FIFO with out_ready=1: vector appears the next cycle (no fall-through).
REQ-022 Pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter width clog2(FIFO_DEPTH)+1 distinguishes full from empty.

Reset
REQ-023 rst_n=0 at a clock edge SHALL clear valid pipeline, FIFO pointers, occupancy, overflow; out_valid=0, dout=0 in the following cycle.
REQ-024 Lane delay data registers need no reset; partial vectors in flight at reset SHALL be discarded (valid pipeline cleared).
REQ-025 in_valid during reset cycles SHALL be ignored.

Configuration
REQ-026 Macro OUTPUT_DESKEW_CNT_EN, when defined, adds output vec_count (16 bits): count of popped vectors, reset 0, saturating at 16'hFFFF.
REQ-027 Without OUTPUT_DESKEW_CNT_EN the vec_count port and its logic SHALL be absent; all other behaviour identical.

Structure
REQ-028 Shared package qrd_pkg holds default LANES, DATA_LENGTH, FIFO_DEPTH constants and the lane word typedef.
REQ-029 Sub-module lane_delay (parameters DEPTH, DATA_LENGTH) implements one lane's shift register; DEPTH=0 is a wire.
REQ-030 output_deskew instantiates LANES lane_delay copies via generate, plus inline valid pipeline and FIFO.

Verification
REQ-031 Single vector: in_valid cycle 10, lane i = 8'h10+i in cycle 10+i, out_ready=1 -> out_valid only in cycle 14, dout lanes {13,12,11,10} hex.
REQ-032 Burst: in_valid cycles 0..7, lane i word = 8*k+i -> vectors k=0..7 in order, cycles 4..11, no overflow.
REQ-033 Backpressure: out_ready=0, 5 vectors with FIFO_DEPTH=4 -> 4 held, 5th dropped, overflow=1; then out_ready=1 -> vectors 0..3 popped in order.
REQ-034 Full plus pop: FIFO full, out_ready=1 same cycle as new write -> occupancy stays 4, overflow stays 0.
REQ-035 Reset mid-flight: rst_n low in cycle n+2 of a vector -> no out_valid ever for it, overflow=0, dout=0.
REQ-036 With OUTPUT_DESKEW_CNT_EN: 3 pops -> vec_count=3; forced 65540 pops -> vec_count=16'hFFFF.
